// File: rtl/usb_ep_rd_stream.sv
// Byte-stream reader for the usb_ep_buf read port: fetches RWIDTH-bit words through a
// 2-slot prefetch and presents them as a little-endian valid/ack byte stream.
module usb_ep_rd_stream #(
    parameter  int unsigned RWIDTH = 16,
    localparam int unsigned ARW    = 11 - $clog2(RWIDTH / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [10:0]       base_addr,
    input  logic [10:0]       len,
    output logic              busy,
    output logic              done,
    output logic [ARW-1:0]    rd_addr_0,
    output logic              rd_en_0,
    input  logic [RWIDTH-1:0] rd_data_1,
    output logic [7:0]        data,
    output logic              valid,
    output logic              last,
    input  logic              ack
);

    localparam int unsigned BYTES = RWIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned LW    = (OFFW > 0) ? OFFW : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [RWIDTH-1:0] slot_q [2];
    logic              wr_q, rd_q;
    logic [1:0]        cnt_q;
    logic              infl_q;
    logic [ARW-1:0]    ptr_q;
    logic [11:0]       wleft_q;
    logic [10:0]       rem_q;
    logic [LW-1:0]     lane_q;

    logic [10:0]       len_c;
    logic [LW-1:0]     off_c;
    logic [12:0]       span_c;
    logic [ARW-1:0]    ptr_c;
    logic              run;
    logic              valid_c;
    logic              take;
    logic              lane_end;
    logic              free;
    logic              issue;
    logic [7:0]        cur_byte;

    always_comb begin
        len_c    = (len > 11'd1024) ? 11'd1024 : len;
        off_c    = LW'(32'(base_addr) % BYTES);
        span_c   = 13'(len_c) + 13'(off_c) + 13'(BYTES - 1);
        ptr_c    = ARW'(base_addr >> OFFW);
        run      = (state_q == StRun);
        cur_byte = 8'(slot_q[rd_q] >> (8 * int'(lane_q)));
        valid_c  = run && (cnt_q != 2'd0) && (rem_q != 11'd0);
        take     = valid_c && ack;
        // Head slot is released after its top lane, or after the final byte of a short tail.
        lane_end = (lane_q == LW'(BYTES - 1)) || (rem_q == 11'd1);
        free     = take && lane_end;
        // Reserve a slot for the returning word, counting the slot freed this cycle.
        issue    = run && !abort && (wleft_q != 12'd0)
                   && ((cnt_q - 2'(free) + 2'(infl_q)) < 2'd2);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = (len_c == 11'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort || (take && rem_q == 11'd1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rd_en_0   = issue;
    assign rd_addr_0 = ptr_q;
    assign data      = cur_byte;
    assign valid     = valid_c;
    assign last      = valid_c && (rem_q == 11'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            infl_q    <= 1'b0;
            ptr_q     <= '0;
            wleft_q   <= '0;
            rem_q     <= '0;
            lane_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                if (start && !abort) begin
                    ptr_q   <= ptr_c;
                    lane_q  <= off_c;
                    rem_q   <= len_c;
                    wleft_q <= 12'(span_c >> OFFW);
                    cnt_q   <= '0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    infl_q  <= 1'b0;
                end
            end else if (run) begin
                if (abort) begin
                    // Drop prefetched words and ignore the word still coming back.
                    cnt_q   <= '0;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    infl_q  <= 1'b0;
                    wleft_q <= '0;
                    rem_q   <= '0;
                end else begin
                    infl_q <= issue;
                    if (issue) begin
                        ptr_q   <= ptr_q + ARW'(1);
                        wleft_q <= wleft_q - 12'd1;
                    end
                    if (infl_q) begin
                        slot_q[wr_q] <= rd_data_1;
                        wr_q         <= ~wr_q;
                    end
                    cnt_q <= cnt_q + 2'(infl_q) - 2'(free);
                    if (take) begin
                        rem_q  <= rem_q - 11'd1;
                        lane_q <= lane_end ? '0 : lane_q + LW'(1);
                        if (lane_end) begin
                            rd_q <= ~rd_q;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_ep_rd_stream.sv
// Bench for usb_ep_rd_stream (RWIDTH=16): buffer model, byte scoreboard and per-scenario
// timing/address checks.
module tb_usb_ep_rd_stream;

    localparam int unsigned RWIDTH = 16;
    localparam int unsigned ARW    = 10;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic              ack       = 1'b0;
    logic [10:0]       base_addr = '0;
    logic [10:0]       len       = '0;
    logic              busy, done, rd_en_0, valid, last;
    logic [ARW-1:0]    rd_addr_0;
    logic [RWIDTH-1:0] rd_data_1 = '0;
    logic [7:0]        data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [2048];
    logic [8:0]  exp_q [$];
    int unsigned rd_log [$];

    always #5 clk = ~clk;

    usb_ep_rd_stream #(.RWIDTH(RWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_addr_0 (rd_addr_0),
        .rd_en_0   (rd_en_0),
        .rd_data_1 (rd_data_1),
        .data      (data),
        .valid     (valid),
        .last      (last),
        .ack       (ack)
    );

    // Buffer model: one-cycle read latency, little-endian lanes.
    always @(posedge clk) begin
        if (rd_en_0) begin
            rd_data_1 <= {mem[2 * int'(rd_addr_0) + 1], mem[2 * int'(rd_addr_0)]};
            rd_log.push_back(32'(rd_addr_0));
        end
    end

    // Stream monitor: pops the scoreboard on every accepted byte and checks hold stability.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_hold) begin
                    n_checks++;
                    if (valid !== 1'b1 || data !== prev_data) begin
                        n_fail++;
                        $display("FAIL hold_stable: got valid=%0b data=%02h, want valid=1 data=%02h",
                                 valid, data, prev_data);
                    end
                end
                if (valid && ack) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stream_extra: got data=%02h last=%0b, want no byte",
                                 data, last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({last, data} !== e) begin
                            n_fail++;
                            $display("FAIL stream_byte: got last=%0b data=%02h, want last=%0b data=%02h",
                                     last, data, e[8], e[7:0]);
                        end
                    end
                end
                prev_hold = valid && !ack && !abort;
                prev_data = data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [10:0] b, input logic [10:0] l);
        int n;
        n = (l > 11'd1024) ? 1024 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), mem[(int'(b) + i) % 2048]});
        end
        base_addr = b;
        len       = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({busy, done, valid, last, rd_en_0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/done/valid/last/rd_en=%05b, want 00000",
                     {busy, done, valid, last, rd_en_0});
        end
        n_checks++;
        if (rd_addr_0 !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d, want 0", rd_addr_0);
        end
        n_checks++;
        if (data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %02h, want 00", data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int first_v = -1;
        int last_c  = -1;
        int done_c  = -1;
        int nv      = 0;
        ack = 1'b1;
        rd_log.delete();
        start_xfer(11'd0, 11'd5);
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (rd_en_0 !== 1'b1 || rd_addr_0 !== '0) begin
                    n_fail++;
                    $display("FAIL basic_first_read: got rd_en=%0b addr=%0d, want 1 and 0",
                             rd_en_0, rd_addr_0);
                end
            end
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = c;
            end
            if (valid && last) last_c = c;
            if (done) done_c = c;
        end
        n_checks++;
        if (first_v != 3 || last_c != 7 || done_c != 8 || nv != 5) begin
            n_fail++;
            $display("FAIL basic_timing: got first=%0d last=%0d done=%0d nvalid=%0d, want 3 7 8 5",
                     first_v, last_c, done_c, nv);
        end
        n_checks++;
        if (rd_log.size() != 3 || rd_log[0] != 0 || rd_log[1] != 1 || rd_log[2] != 2) begin
            n_fail++;
            $display("FAIL basic_reads: got %0d reads %p, want 0,1,2", rd_log.size(), rd_log);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: got %0d bytes left, want 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_unaligned();
        int first_v = -1;
        int done_c  = -1;
        ack = 1'b1;
        rd_log.delete();
        start_xfer(11'd3, 11'd3);
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (valid && first_v < 0) first_v = c;
            if (done) done_c = c;
        end
        n_checks++;
        if (first_v != 3 || done_c < 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL unaligned_run: got first=%0d done=%0d left=%0d, want 3 seen 0",
                     first_v, done_c, exp_q.size());
        end
        n_checks++;
        if (rd_log.size() != 2 || rd_log[0] != 1 || rd_log[1] != 2) begin
            n_fail++;
            $display("FAIL unaligned_reads: got %p, want 1,2", rd_log);
        end
        step();
    endtask

    task automatic test_wrap();
        int done_c = -1;
        ack = 1'b1;
        rd_log.delete();
        start_xfer(11'd2046, 11'd4);
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (done) done_c = c;
        end
        n_checks++;
        if (done_c < 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_run: got done=%0d left=%0d, want seen and 0", done_c, exp_q.size());
        end
        n_checks++;
        if (rd_log.size() != 2 || rd_log[0] != 1023 || rd_log[1] != 0) begin
            n_fail++;
            $display("FAIL wrap_reads: got %p, want 1023,0", rd_log);
        end
        step();
    endtask

    task automatic test_zero_len();
        int  done_c = -1;
        logic any_v = 1'b0;
        logic any_r = 1'b0;
        ack = 1'b1;
        start_xfer(11'd7, 11'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (valid) any_v = 1'b1;
            if (rd_en_0) any_r = 1'b1;
            if (done && done_c < 0) done_c = c;
            if (c == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL zero_busy: got %0b, want 1", busy);
                end
            end
        end
        n_checks++;
        if (done_c != 1 || any_v || any_r) begin
            n_fail++;
            $display("FAIL zero_len: got done=%0d valid_seen=%0b read_seen=%0b, want 1 0 0",
                     done_c, any_v, any_r);
        end
        step();
    endtask

    task automatic test_ack_toggle();
        int done_c = -1;
        ack = 1'b0;
        rd_log.delete();
        start_xfer(11'd9, 11'd8);
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (done) done_c = c;
            @(posedge clk);
            #1;
            ack   = ~ack;
            // A second start mid-transfer must be ignored.
            start = (c == 4);
            if (c == 4) begin
                base_addr = 11'd100;
                len       = 11'd3;
            end
        end
        start = 1'b0;
        n_checks++;
        if (done_c < 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL toggle_run: got done=%0d left=%0d, want seen and 0", done_c, exp_q.size());
        end
        n_checks++;
        if (rd_log.size() != 5 || rd_log[0] != 4 || rd_log[4] != 8) begin
            n_fail++;
            $display("FAIL toggle_reads: got %p, want 4..8", rd_log);
        end
        ack = 1'b1;
        step();
    endtask

    task automatic test_clamp();
        int done_c = -1;
        int nb     = 0;
        ack = 1'b1;
        rd_log.delete();
        start_xfer(11'd0, 11'd1100);
        for (int c = 1; c <= 1100 && done_c < 0; c++) begin
            @(negedge clk);
            if (valid && ack) nb++;
            if (done) done_c = c;
        end
        n_checks++;
        if (done_c < 0 || nb != 1024 || exp_q.size() != 0 || rd_log.size() != 512) begin
            n_fail++;
            $display("FAIL clamp: got done=%0d bytes=%0d left=%0d reads=%0d, want seen 1024 0 512",
                     done_c, nb, exp_q.size(), rd_log.size());
        end
        step();
    endtask

    task automatic test_abort();
        int acks   = 0;
        int done_c = -1;
        ack = 1'b1;
        start_xfer(11'd0, 11'd10);
        for (int c = 1; c <= 20 && acks < 2; c++) begin
            @(negedge clk);
            if (valid && ack) acks++;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        ack   = 1'b0;
        step();
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_stop: got valid=%0b done=%0b, want 0 1", valid, done);
        end
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%0b, want 0", busy);
        end
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'hA5;
        step();
        ack = 1'b1;
        start_xfer(11'd0, 11'd6);
        for (int c = 1; c <= 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (done) done_c = c;
        end
        n_checks++;
        if (done_c < 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_restart: got done=%0d left=%0d, want seen and 0",
                     done_c, exp_q.size());
        end
        step();
    endtask

    task automatic test_start_abort_idle();
        logic seen = 1'b0;
        base_addr = 11'd0;
        len       = 11'd4;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (busy || done || valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL start_abort_idle: got activity=1, want 0");
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        ack = 1'b1;
        start_xfer(11'd0, 11'd20);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({busy, done, valid, rd_en_0} !== 4'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got busy/done/valid/rd_en=%04b data=%02h, want 0000 00",
                     {busy, done, valid, rd_en_0}, data);
        end
        exp_q.delete();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_done: got activity after reset=1, want 0");
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        test_reset();
        test_basic();
        test_unaligned();
        test_wrap();
        test_zero_len();
        test_ack_toggle();
        test_clamp();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
